// File: rtl/cpu_mul_wb.sv
// rtl/cpu_mul_wb.sv - pipelined multiplier with register-file writeback and hazard query; MUL_HIGH_EN adds high-half results
module cpu_mul_wb #(
    parameter int REG_WIDTH  = 32,
    parameter int REG_ADDR_W = 5,
    parameter int MUL_STAGES = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  issue_valid,
    input  logic [REG_ADDR_W-1:0] issue_rd,
    input  logic [REG_WIDTH-1:0]  issue_a,
    input  logic [REG_WIDTH-1:0]  issue_b,
`ifdef MUL_HIGH_EN
    input  logic                  issue_high,
    input  logic                  issue_signed,
`endif
    input  logic                  flush,
    input  logic [REG_ADDR_W-1:0] query_reg_a,
    input  logic [REG_ADDR_W-1:0] query_reg_b,
    output logic                  pending_a,
    output logic                  pending_b,
    output logic                  busy,
    output logic                  write_enable_mul,
    output logic [REG_ADDR_W-1:0] write_reg_mul,
    output logic [REG_WIDTH-1:0]  write_data_mul
);

`ifdef MUL_HIGH_EN
    localparam int PROD_W = 2 * REG_WIDTH;
`else
    localparam int PROD_W = REG_WIDTH;
`endif
    localparam int HALF_W  = PROD_W / 2;
    localparam int UPPER_W = PROD_W - HALF_W;
    localparam int LAST    = MUL_STAGES - 1;

    logic [PROD_W-1:0]     a_ext;
    logic [PROD_W-1:0]     b_ext;
    logic [PROD_W-1:0]     b_lo_ext;
    logic [PROD_W-1:0]     s0_pp;
    logic [UPPER_W-1:0]    s0_a;
    logic [UPPER_W-1:0]    s0_bh;
    logic [UPPER_W-1:0]    hi_pp;
    logic [PROD_W-1:0]     sum1;
    logic [PROD_W-1:0]     pre_last;
    logic [REG_WIDTH-1:0]  wb_sel;
    logic [REG_WIDTH-1:0]  last_data;
    logic [MUL_STAGES-1:0] stg_valid;
    logic [REG_ADDR_W-1:0] stg_rd [MUL_STAGES];
    logic                  take_last;

    // Operands are widened so the truncated product is exact for signed and unsigned alike
`ifdef MUL_HIGH_EN
    logic [MUL_STAGES-2:0] stg_high;
    assign a_ext  = {{REG_WIDTH{issue_signed & issue_a[REG_WIDTH-1]}}, issue_a};
    assign b_ext  = {{REG_WIDTH{issue_signed & issue_b[REG_WIDTH-1]}}, issue_b};
    assign wb_sel = stg_high[LAST-1] ? pre_last[PROD_W-1:REG_WIDTH] : pre_last[REG_WIDTH-1:0];
`else
    assign a_ext  = issue_a;
    assign b_ext  = issue_b;
    assign wb_sel = pre_last;
`endif

    assign b_lo_ext  = {{UPPER_W{1'b0}}, b_ext[HALF_W-1:0]};
    assign hi_pp     = s0_a * s0_bh;
    assign sum1      = s0_pp + {hi_pp, {HALF_W{1'b0}}};
    assign take_last = stg_valid[LAST-1] & ~flush;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stg_valid <= '0;
            for (int i = 0; i < MUL_STAGES; i++) stg_rd[i] <= '0;
            s0_pp     <= '0;
            s0_a      <= '0;
            s0_bh     <= '0;
            last_data <= '0;
`ifdef MUL_HIGH_EN
            stg_high  <= '0;
`endif
        end else begin
            stg_valid <= flush ? '0 : {stg_valid[MUL_STAGES-2:0], issue_valid};
            stg_rd[0] <= issue_rd;
            for (int i = 1; i < LAST; i++) stg_rd[i] <= stg_rd[i-1];
            // Output-stage index and data are zeroed whenever the slot is empty
            stg_rd[LAST] <= take_last ? stg_rd[LAST-1] : '0;
            last_data    <= take_last ? wb_sel : '0;
            s0_pp        <= a_ext * b_lo_ext;
            s0_a         <= a_ext[UPPER_W-1:0];
            s0_bh        <= b_ext[PROD_W-1:HALF_W];
`ifdef MUL_HIGH_EN
            stg_high[0]  <= issue_high;
            for (int i = 1; i < MUL_STAGES - 1; i++) stg_high[i] <= stg_high[i-1];
`endif
        end
    end

    generate
        if (MUL_STAGES == 2) begin : g_short
            assign pre_last = sum1;
        end else begin : g_long
            logic [PROD_W-1:0] pipe [1:MUL_STAGES-2];
            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    for (int i = 1; i <= MUL_STAGES - 2; i++) pipe[i] <= '0;
                end else begin
                    pipe[1] <= sum1;
                    for (int i = 2; i <= MUL_STAGES - 2; i++) pipe[i] <= pipe[i-1];
                end
            end
            assign pre_last = pipe[MUL_STAGES-2];
        end
    endgenerate

    always_comb begin
        pending_a = 1'b0;
        pending_b = 1'b0;
        for (int i = 0; i < MUL_STAGES; i++) begin
            if (stg_valid[i] && (stg_rd[i] == query_reg_a)) pending_a = 1'b1;
            if (stg_valid[i] && (stg_rd[i] == query_reg_b)) pending_b = 1'b1;
        end
    end

    assign busy             = |stg_valid;
    assign write_enable_mul = stg_valid[LAST];
    assign write_reg_mul    = stg_rd[LAST];
    assign write_data_mul   = last_data;

endmodule

// File: tb/tb_cpu_mul_wb.sv
// tb/tb_cpu_mul_wb.sv - directed self-checking bench for cpu_mul_wb
module tb_cpu_mul_wb;
    logic        clock = 1'b0;
    logic        reset;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic [31:0] issue_a;
    logic [31:0] issue_b;
`ifdef MUL_HIGH_EN
    logic        issue_high;
    logic        issue_signed;
`endif
    logic        flush;
    logic [4:0]  query_reg_a;
    logic [4:0]  query_reg_b;
    logic        pending_a;
    logic        pending_b;
    logic        busy;
    logic        write_enable_mul;
    logic [4:0]  write_reg_mul;
    logic [31:0] write_data_mul;

    int n_checks = 0;
    int n_fail   = 0;

    cpu_mul_wb dut (
        .clock(clock), .reset(reset),
        .issue_valid(issue_valid), .issue_rd(issue_rd),
        .issue_a(issue_a), .issue_b(issue_b),
`ifdef MUL_HIGH_EN
        .issue_high(issue_high), .issue_signed(issue_signed),
`endif
        .flush(flush), .query_reg_a(query_reg_a), .query_reg_b(query_reg_b),
        .pending_a(pending_a), .pending_b(pending_b), .busy(busy),
        .write_enable_mul(write_enable_mul), .write_reg_mul(write_reg_mul),
        .write_data_mul(write_data_mul)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic offer(input logic [4:0] rd, input logic [31:0] a, input logic [31:0] b);
        issue_valid = 1'b1;
        issue_rd    = rd;
        issue_a     = a;
        issue_b     = b;
    endtask

    task automatic idle();
        issue_valid = 1'b0;
        issue_rd    = '0;
        issue_a     = '0;
        issue_b     = '0;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_we"},   write_enable_mul, 1'b0);
        check({tag, "_reg"},  write_reg_mul, 5'd0);
        check({tag, "_data"}, write_data_mul, 32'd0);
    endtask

    // Issue one op into an empty pipe, expect writeback only after the fourth edge
    task automatic run_single(input logic [4:0] rd, input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] exp_data, input string tag);
        offer(rd, a, b);
        query_reg_a = rd;
        query_reg_b = rd + 5'd1;
        check({tag, "_offer_pend"}, pending_a, 1'b0);
        for (int c = 0; c < 5; c++) begin
            tick();
            idle();
            if (c == 3) begin
                check($sformatf("%s_we%0d", tag, c), write_enable_mul, 1'b1);
                check({tag, "_reg"},  write_reg_mul, rd);
                check({tag, "_data"}, write_data_mul, exp_data);
            end else begin
                check_quiet($sformatf("%s_c%0d", tag, c));
            end
            check($sformatf("%s_busy%0d", tag, c), busy, c < 4);
            check($sformatf("%s_pa%0d", tag, c), pending_a, c < 4);
            check($sformatf("%s_pb%0d", tag, c), pending_b, 1'b0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        flush = 1'b0;
        query_reg_a = 5'd0;
        query_reg_b = 5'd0;
`ifdef MUL_HIGH_EN
        issue_high   = 1'b0;
        issue_signed = 1'b0;
`endif
        idle();
        #2;
        check_quiet("reset");
        check("reset_busy", busy, 1'b0);
        check("reset_pa", pending_a, 1'b0);
        check("reset_pb", pending_b, 1'b0);
        tick();
        tick();
        reset = 1'b0;

        run_single(5'd3, 32'd7, 32'd6, 32'd42, "single");
        run_single(5'd0, 32'd3, 32'd9, 32'd27, "rd0");
        run_single(5'd7, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE, "wrap");
        run_single(5'd8, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFF1, "neg_lo");
`ifdef MUL_HIGH_EN
        issue_high = 1'b1; issue_signed = 1'b0;
        run_single(5'd10, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, "high_u");
        issue_high = 1'b1; issue_signed = 1'b1;
        run_single(5'd10, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, "high_s");
        issue_high = 1'b0; issue_signed = 1'b1;
        run_single(5'd10, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE, "low_s");
        issue_high = 1'b0; issue_signed = 1'b0;
`endif

        // Back-to-back: rd=1..4, data 10..40
        query_reg_a = 5'd2;
        query_reg_b = 5'd9;
        for (int c = 0; c < 8; c++) begin
            if (c < 4) offer(5'(c + 1), 32'(c + 1), 32'd10);
            tick();
            idle();
            if (c >= 3 && c <= 6) begin
                check($sformatf("b2b_we%0d", c), write_enable_mul, 1'b1);
                check($sformatf("b2b_reg%0d", c), write_reg_mul, 5'(c - 2));
                check($sformatf("b2b_data%0d", c), write_data_mul, 32'(10 * (c - 2)));
            end else begin
                check_quiet($sformatf("b2b_c%0d", c));
            end
            check($sformatf("b2b_busy%0d", c), busy, c <= 6);
            check($sformatf("b2b_pa%0d", c), pending_a, (c >= 1) && (c <= 4));
            check($sformatf("b2b_pb%0d", c), pending_b, 1'b0);
        end

        // Flush: rd=5 committed during the flush cycle, rd=6 and the same-cycle offer dropped
        query_reg_a = 5'd6;
        query_reg_b = 5'd7;
        for (int c = 0; c < 9; c++) begin
            if (c == 0) offer(5'd5, 32'd5, 32'd5);
            if (c == 1) offer(5'd6, 32'd6, 32'd6);
            if (c == 4) begin
                offer(5'd7, 32'd2, 32'd2);
                flush = 1'b1;
            end
            tick();
            idle();
            flush = 1'b0;
            if (c == 3) begin
                check("flush_we", write_enable_mul, 1'b1);
                check("flush_reg", write_reg_mul, 5'd5);
                check("flush_data", write_data_mul, 32'd25);
                check("flush_pa_pre", pending_a, 1'b1);
            end else begin
                check_quiet($sformatf("flush_c%0d", c));
            end
            if (c >= 4) begin
                check($sformatf("flush_busy%0d", c), busy, 1'b0);
                check($sformatf("flush_pa%0d", c), pending_a, 1'b0);
                check($sformatf("flush_pb%0d", c), pending_b, 1'b0);
            end
        end

        // Asynchronous reset mid-operation
        query_reg_a = 5'd9;
        offer(5'd9, 32'd3, 32'd3);
        tick();
        idle();
        tick();
        check("rst_busy_pre", busy, 1'b1);
        check("rst_pa_pre", pending_a, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        check("rst_busy", busy, 1'b0);
        check("rst_pa", pending_a, 1'b0);
        check_quiet("rst_async");
        tick();
        reset = 1'b0;
        run_single(5'd11, 32'd4, 32'd5, 32'd20, "post_rst");

        // Same rd twice: writebacks 10 then 20
        query_reg_a = 5'd2;
        query_reg_b = 5'd0;
        for (int c = 0; c < 6; c++) begin
            if (c == 0) offer(5'd2, 32'd2, 32'd5);
            if (c == 1) offer(5'd2, 32'd4, 32'd5);
            tick();
            idle();
            if (c == 3 || c == 4) begin
                check($sformatf("same_we%0d", c), write_enable_mul, 1'b1);
                check($sformatf("same_reg%0d", c), write_reg_mul, 5'd2);
                check($sformatf("same_data%0d", c), write_data_mul, (c == 3) ? 32'd10 : 32'd20);
            end else begin
                check_quiet($sformatf("same_c%0d", c));
            end
            check($sformatf("same_pa%0d", c), pending_a, c <= 4);
            check($sformatf("same_pb%0d", c), pending_b, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/cpu_mul_wb.md
CPU_MUL_WB -- requirements
Module: cpu_mul_wb

Interface
REQ-001 Parameters (name, default, meaning), one per line:
  REG_WIDTH  32  operand/result width
  REG_ADDR_W  5  destination register index width (32 registers)
  MUL_STAGES  4  pipeline depth, minimum 2
REQ-002 Ports (name, direction, width, meaning), one per line; all widths are in bits:
  clock  in  1  single clock
  reset  in  1  asynchronous, active-high
  issue_valid  in  1  new multiply offered this cycle
  issue_rd  in  REG_ADDR_W  destination register
  issue_a  in  REG_WIDTH  operand A
  issue_b  in  REG_WIDTH  operand B
  flush  in  1  kill all in-flight multiplies
  query_reg_a  in  REG_ADDR_W  hazard query A
  query_reg_b  in  REG_ADDR_W  hazard query B
  pending_a  out  1  query_reg_a is an in-flight destination
  pending_b  out  1  query_reg_b is an in-flight destination
  busy  out  1  any multiply in flight
  write_enable_mul  out  1  register-file multiply write enable
  write_reg_mul  out  REG_ADDR_W  register-file multiply write index
  write_data_mul  out  REG_WIDTH  register-file multiply write data
REQ-003 The block SHALL use exactly one clock domain, with an asynchronous active-high reset named reset.

Function
REQ-004 The pipeline SHALL accept one issue per cycle, with no backpressure, whenever issue_valid=1 and flush=0.
REQ-005 An issue accepted at clock edge N SHALL produce write_enable_mul=1 during cycle N+MUL_STAGES, after exactly MUL_STAGES edges, with that issue's issue_rd and product.
REQ-006 The pipeline SHALL be fully pipelined: back-to-back issues SHALL produce back-to-back writebacks in issue order.
REQ-007 write_data_mul SHALL equal the low REG_WIDTH bits of issue_a*issue_b, which are identical for signed and unsigned operands; the partial product is split across stages.
REQ-008 All three write_*_mul outputs SHALL come directly from last-stage registers, with no combinational path from the issue inputs.
REQ-009 When write_enable_mul=0, write_reg_mul and write_data_mul SHALL hold 0.
REQ-010 Flush asserted at edge N SHALL clear every stage valid bit, including the output stage, and SHALL drop any issue offered in the same cycle.
REQ-011 The writeback presented during the flush cycle itself is already committed and SHALL NOT be suppressed.
REQ-012 pending_a SHALL be a combinational OR over all valid stages, output stage included, of (stage_rd == query_reg_a); pending_b SHALL be formed the same way from query_reg_b.
REQ-013 pending_a and pending_b SHALL be 0 when no stage is valid.
REQ-014 The issue currently being offered SHALL NOT contribute to pending_a or pending_b.
REQ-015 busy SHALL be the OR of all stage valid bits.
REQ-016 Register index 0 SHALL be an ordinary destination, with no special casing.
REQ-017 The block SHALL NOT track write-after-write conflicts; two in-flight ops to the same rd SHALL both write back, in order.

Reset
REQ-018 Asserting reset SHALL immediately clear all valid bits, busy, pending_a/b and write_enable_mul, and SHALL drive write_reg_mul and write_data_mul to 0, independent of clock.
REQ-019 A reset asserted mid-operation SHALL discard all in-flight operations; no writeback SHALL occur for any of them after deassertion.
REQ-020 The first issue SHALL be accepted at the first clock edge after reset deasserts.

Configuration
REQ-021 The macro MUL_HIGH_EN SHALL select whether the high-half multiply feature is compiled in.
REQ-022 With MUL_HIGH_EN defined, the block SHALL add the inputs issue_high (1 bit) and issue_signed (1 bit), both carried down the pipeline with their issue.
REQ-023 With MUL_HIGH_EN defined and issue_high=1, write_data_mul SHALL be bits [2*REG_WIDTH-1:REG_WIDTH] of the product; issue_signed=1 SHALL select a signed x signed product, and 0 SHALL select unsigned x unsigned.
REQ-024 With MUL_HIGH_EN defined and issue_high=0, the block SHALL behave as REQ-007.
REQ-025 Without MUL_HIGH_EN, the ports issue_high and issue_signed SHALL be absent and the full product width SHALL NOT be synthesized beyond the low half.

Verification
REQ-026 The bench SHALL cover the following directed scenarios:
  Single op: issue rd=3, a=7, b=6 at edge 0 -> write_enable_mul=1, write_reg_mul=3, write_data_mul=42 in cycle 4 only.
  Wrap-around: a=0xFFFFFFFF, b=2 -> write_data_mul=0xFFFFFFFE. With MUL_HIGH_EN: high=1, signed=0 -> 0x00000001; high=1, signed=1 -> 0xFFFFFFFF.
  Back-to-back: 4 issues rd=1..4 on consecutive edges -> 4 consecutive writebacks rd=1..4; busy=1 throughout; pending_a=1 for query_reg_a=2 until rd=2 leaves the output stage.
  Flush: issue rd=5 and rd=6 on edges 0 and 1, flush in cycle 4 while rd=5 is on the output -> rd=5 written; rd=6 never written; busy=0 after edge 4.
  Reset: assert reset asynchronously two cycles after issue rd=9 -> all outputs 0 immediately; no write to rd=9 after release; an issue at the first post-reset edge completes normally.
  Same rd: issue rd=2 with products 10 then 20 -> two writebacks to rd=2 in order (10, then 20); pending for rd=2 stays 1 until the second leaves.
